// File: rtl/bitmap_slicer.sv
// Bitmap buffer for the compare/accumulate ALU: one-shot ROWS x COLS load, then three
// independent request-driven slice streams (row words, descending and ascending bit-columns).
module bitmap_slicer #(
  parameter int unsigned ROWS = 24,
  parameter int unsigned COLS = 64,
  parameter int unsigned WRAP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wren,
  input  logic [ROWS*COLS-1:0] data,
  output logic                 alustart,
  input  logic                 word_req,
  output logic [COLS-1:0]      word_out,
  output logic                 word_valid,
  output logic                 word_last,
  input  logic                 desc_req,
  output logic [ROWS-1:0]      desc_out,
  output logic                 desc_valid,
  output logic                 desc_last,
  input  logic                 asc_req,
  output logic [ROWS-1:0]      asc_out,
  output logic                 asc_valid,
  output logic                 asc_last,
  output logic [2:0]           done
);

  localparam int unsigned BITS = ROWS * COLS;
  localparam int unsigned WW   = $clog2(ROWS);
  localparam int unsigned CW   = $clog2(COLS);

  localparam logic [WW-1:0] WORD_END = WW'(ROWS - 1);
  localparam logic [CW-1:0] COL_END  = CW'(COLS - 1);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } stream_state_e;

  logic [BITS-1:0] bitmap_q, bitmap_d;
  logic            alustart_q, alustart_d;
  logic [2:0]      done_q, done_d;

  stream_state_e   word_state_q, word_state_d;
  logic [WW-1:0]   word_ptr_q, word_ptr_d;
  logic [COLS-1:0] word_out_q, word_out_d;
  logic            word_valid_q, word_valid_d;
  logic            word_last_q, word_last_d;

  stream_state_e   desc_state_q, desc_state_d;
  logic [CW-1:0]   desc_ptr_q, desc_ptr_d;
  logic [ROWS-1:0] desc_out_q, desc_out_d;
  logic            desc_valid_q, desc_valid_d;
  logic            desc_last_q, desc_last_d;

  stream_state_e   asc_state_q, asc_state_d;
  logic [CW-1:0]   asc_ptr_q, asc_ptr_d;
  logic [ROWS-1:0] asc_out_q, asc_out_d;
  logic            asc_valid_q, asc_valid_d;
  logic            asc_last_q, asc_last_d;

  logic [COLS-1:0] rows  [ROWS];
  logic [ROWS-1:0] cols  [COLS];
  logic [COLS-1:0] word_sel;
  logic [ROWS-1:0] desc_sel;
  logic [ROWS-1:0] asc_sel;

  // Row and column views of the stored bitmap.
  always_comb begin
    for (int r = 0; r < int'(ROWS); r++) begin
      rows[r] = bitmap_q[r*COLS +: COLS];
    end
    for (int c = 0; c < int'(COLS); c++) begin
      cols[c] = '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        cols[c][r] = bitmap_q[r*COLS + c];
      end
    end
  end

  // Element select at each stream pointer.
  always_comb begin
    word_sel = '0;
    desc_sel = '0;
    asc_sel  = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (word_ptr_q == WW'(r)) word_sel = rows[r];
    end
    for (int c = 0; c < int'(COLS); c++) begin
      if (desc_ptr_q == CW'(c)) desc_sel = cols[c];
      if (asc_ptr_q == CW'(c))  asc_sel  = cols[c];
    end
  end

  // Next-state: a load overrides everything and drops same-cycle requests.
  always_comb begin
    bitmap_d     = bitmap_q;
    alustart_d   = 1'b0;
    done_d       = done_q;

    word_state_d = word_state_q;
    word_ptr_d   = word_ptr_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    word_last_d  = 1'b0;

    desc_state_d = desc_state_q;
    desc_ptr_d   = desc_ptr_q;
    desc_out_d   = desc_out_q;
    desc_valid_d = 1'b0;
    desc_last_d  = 1'b0;

    asc_state_d  = asc_state_q;
    asc_ptr_d    = asc_ptr_q;
    asc_out_d    = asc_out_q;
    asc_valid_d  = 1'b0;
    asc_last_d   = 1'b0;

    if (wren) begin
      bitmap_d     = data;
      alustart_d   = 1'b1;
      done_d       = 3'b000;
      word_state_d = S_ACTIVE;
      word_ptr_d   = '0;
      desc_state_d = S_ACTIVE;
      desc_ptr_d   = COL_END;
      asc_state_d  = S_ACTIVE;
      asc_ptr_d    = '0;
    end else begin
      if (word_req && word_state_q == S_ACTIVE) begin
        word_out_d   = word_sel;
        word_valid_d = 1'b1;
        if (word_ptr_q == WORD_END) begin
          word_last_d = 1'b1;
          word_ptr_d  = '0;
          if (WRAP == 0) begin
            word_state_d = S_DONE;
            done_d[2]    = 1'b1;
          end
        end else begin
          word_ptr_d = word_ptr_q + WW'(1);
        end
      end

      if (desc_req && desc_state_q == S_ACTIVE) begin
        desc_out_d   = desc_sel;
        desc_valid_d = 1'b1;
        if (desc_ptr_q == '0) begin
          desc_last_d = 1'b1;
          desc_ptr_d  = COL_END;
          if (WRAP == 0) begin
            desc_state_d = S_DONE;
            done_d[1]    = 1'b1;
          end
        end else begin
          desc_ptr_d = desc_ptr_q - CW'(1);
        end
      end

      if (asc_req && asc_state_q == S_ACTIVE) begin
        asc_out_d   = asc_sel;
        asc_valid_d = 1'b1;
        if (asc_ptr_q == COL_END) begin
          asc_last_d = 1'b1;
          asc_ptr_d  = '0;
          if (WRAP == 0) begin
            asc_state_d = S_DONE;
            done_d[0]   = 1'b1;
          end
        end else begin
          asc_ptr_d = asc_ptr_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap_q     <= '0;
      alustart_q   <= 1'b0;
      done_q       <= 3'b000;
      word_state_q <= S_EMPTY;
      word_ptr_q   <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      desc_state_q <= S_EMPTY;
      desc_ptr_q   <= '0;
      desc_out_q   <= '0;
      desc_valid_q <= 1'b0;
      desc_last_q  <= 1'b0;
      asc_state_q  <= S_EMPTY;
      asc_ptr_q    <= '0;
      asc_out_q    <= '0;
      asc_valid_q  <= 1'b0;
      asc_last_q   <= 1'b0;
    end else begin
      bitmap_q     <= bitmap_d;
      alustart_q   <= alustart_d;
      done_q       <= done_d;
      word_state_q <= word_state_d;
      word_ptr_q   <= word_ptr_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
      desc_state_q <= desc_state_d;
      desc_ptr_q   <= desc_ptr_d;
      desc_out_q   <= desc_out_d;
      desc_valid_q <= desc_valid_d;
      desc_last_q  <= desc_last_d;
      asc_state_q  <= asc_state_d;
      asc_ptr_q    <= asc_ptr_d;
      asc_out_q    <= asc_out_d;
      asc_valid_q  <= asc_valid_d;
      asc_last_q   <= asc_last_d;
    end
  end

  assign alustart   = alustart_q;
  assign done       = done_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign word_last  = word_last_q;
  assign desc_out   = desc_out_q;
  assign desc_valid = desc_valid_q;
  assign desc_last  = desc_last_q;
  assign asc_out    = asc_out_q;
  assign asc_valid  = asc_valid_q;
  assign asc_last   = asc_last_q;

endmodule
